// File: rtl/if_id_buffer.sv
// IF/ID decoupling stage: 2-entry skid buffer between fetch and decode with PC+8 link value.
// Optional fetch address check (AdEL) enabled by defining IF_EXC_EN.
module if_id_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc8,
    input  logic        flush,
    output logic [4:0]  exc_code
);

    localparam int unsigned W    = 32;
    localparam int unsigned EW   = 5;
    localparam logic [EW-1:0] EXC_ADEL = EW'(4);

    logic         m_valid_q, m_valid_d;
    logic [W-1:0] m_pc_q,    m_pc_d;
    logic [W-1:0] m_instr_q, m_instr_d;
    logic         s_valid_q, s_valid_d;
    logic [W-1:0] s_pc_q,    s_pc_d;
    logic [W-1:0] s_instr_q, s_instr_d;
    logic         in_ready_q, in_ready_d;
    logic         accept_c, consume_c;
    logic [W-1:0] in_instr_c;

`ifdef IF_EXC_EN
    logic [EW-1:0] m_exc_q, m_exc_d;
    logic [EW-1:0] s_exc_q, s_exc_d;
    logic [EW-1:0] in_exc_c;

    // Misaligned or out-of-range fetches become a nop carrying AdEL.
    always_comb begin
        in_exc_c   = '0;
        in_instr_c = in_instr;
        if ((in_pc[1:0] != 2'b00) || (in_pc < IMEM_LO) || (in_pc > IMEM_HI)) begin
            in_exc_c   = EXC_ADEL;
            in_instr_c = '0;
        end
    end

    assign exc_code = m_exc_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{IMEM_LO, IMEM_HI, EXC_ADEL};
    assign in_instr_c = in_instr;
    assign exc_code   = '0;
`endif

    assign accept_c  = in_valid & in_ready_q;
    assign consume_c = m_valid_q & out_ready;

    // Next-state: flush empties both entries; otherwise skid refills main before new beats.
    always_comb begin
        m_valid_d = m_valid_q;
        m_pc_d    = m_pc_q;
        m_instr_d = m_instr_q;
        s_valid_d = s_valid_q;
        s_pc_d    = s_pc_q;
        s_instr_d = s_instr_q;
`ifdef IF_EXC_EN
        m_exc_d   = m_exc_q;
        s_exc_d   = s_exc_q;
`endif
        if (flush) begin
            m_valid_d = 1'b0;
            m_instr_d = '0;
            s_valid_d = 1'b0;
`ifdef IF_EXC_EN
            m_exc_d   = '0;
`endif
        end else if (!m_valid_q || consume_c) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_pc_d    = s_pc_q;
                m_instr_d = s_instr_q;
                s_valid_d = accept_c;
`ifdef IF_EXC_EN
                m_exc_d   = s_exc_q;
`endif
                if (accept_c) begin
                    s_pc_d    = in_pc;
                    s_instr_d = in_instr_c;
`ifdef IF_EXC_EN
                    s_exc_d   = in_exc_c;
`endif
                end
            end else if (accept_c) begin
                m_valid_d = 1'b1;
                m_pc_d    = in_pc;
                m_instr_d = in_instr_c;
`ifdef IF_EXC_EN
                m_exc_d   = in_exc_c;
`endif
            end else begin
                m_valid_d = 1'b0;
                m_instr_d = '0;
`ifdef IF_EXC_EN
                m_exc_d   = '0;
`endif
            end
        end else if (accept_c) begin
            s_valid_d = 1'b1;
            s_pc_d    = in_pc;
            s_instr_d = in_instr_c;
`ifdef IF_EXC_EN
            s_exc_d   = in_exc_c;
`endif
        end
        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q  <= 1'b0;
            m_pc_q     <= RESET_PC;
            m_instr_q  <= '0;
            s_valid_q  <= 1'b0;
            s_pc_q     <= '0;
            s_instr_q  <= '0;
            in_ready_q <= 1'b1;
`ifdef IF_EXC_EN
            m_exc_q    <= '0;
            s_exc_q    <= '0;
`endif
        end else begin
            m_valid_q  <= m_valid_d;
            m_pc_q     <= m_pc_d;
            m_instr_q  <= m_instr_d;
            s_valid_q  <= s_valid_d;
            s_pc_q     <= s_pc_d;
            s_instr_q  <= s_instr_d;
            in_ready_q <= in_ready_d;
`ifdef IF_EXC_EN
            m_exc_q    <= m_exc_d;
            s_exc_q    <= s_exc_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid_q;
    assign out_pc    = m_pc_q;
    assign out_instr = m_instr_q;
    assign out_pc8   = m_pc_q + W'(8);

endmodule
